iq_wide: RTL and testbench

//  Parametrised multi-lane instruction queue between fetch and decode/rename.

---
 rtl/iq_wide.sv | 161 ++++++++++++++++
 tb/tb_iq_wide.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/iq_wide.sv
// rtl/iq_wide.sv - multi-lane instruction queue between fetch and decode
// Circular store with a separate occupancy count; issue lanes are registered.
module iq_wide #(
  parameter int DEPTH = 16,
  parameter int W     = 2,
  parameter int DW    = 32
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic                       stall_backend,
  input  logic [$clog2(W+1)-1:0]     deq_max,
  input  logic [W-1:0]               in_valid,
  input  logic [W*DW-1:0]            in_inst,
  input  logic [W*DW-1:0]            in_pc4,
  input  logic [W-1:0]               in_br_valid,
  input  logic [W*DW-1:0]            in_btb_pc,
  input  logic [W-1:0]               in_dir_pred,
  output logic                       in_ready,
  output logic [W-1:0]               out_valid,
  output logic [W*DW-1:0]            out_inst,
  output logic [W*DW-1:0]            out_pc4,
  output logic [W-1:0]               out_br_valid,
  output logic [W*DW-1:0]            out_btb_pc,
  output logic [W-1:0]               out_dir_pred,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       empty,
  output logic                       full
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [CW-1:0] W_C     = CW'(W);

  logic [DW-1:0] mem_inst [DEPTH];
  logic [DW-1:0] mem_pc4  [DEPTH];
  logic [DW-1:0] mem_btb  [DEPTH];
  logic          mem_br   [DEPTH];
  logic          mem_dir  [DEPTH];

  logic [PW-1:0] head, tail;
  logic [PW-1:0] wr_idx [W];
  logic [PW-1:0] rd_idx [W];

  logic [CW-1:0] n_enq, n_acc, n_deq;
  logic          enq_ok, deq_go, run;

  assign in_ready = (DEPTH_C - count) >= W_C;
  assign empty    = (count == '0);
  assign full     = (count == DEPTH_C);

  // Only the unbroken run of valid lanes starting at lane 0 is taken.
  always_comb begin
    n_enq = '0;
    run   = 1'b1;
    for (int i = 0; i < W; i++) begin
      run = run & in_valid[i];
      if (run) n_enq = CW'(i + 1);
    end
  end

  assign enq_ok = in_ready && (n_enq != '0);
  assign n_acc  = enq_ok ? n_enq : '0;
  assign deq_go = !stall_backend && (deq_max != '0);

  always_comb begin
    n_deq = '0;
    if (deq_go) begin
      n_deq = count;
      if (CW'(deq_max) < n_deq) n_deq = CW'(deq_max);
      if (W_C < n_deq)          n_deq = W_C;
    end
  end

  always_comb begin
    for (int i = 0; i < W; i++) begin
      wr_idx[i] = tail + PW'(i);
      rd_idx[i] = head + PW'(i);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else if (flush) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      head  <= head + PW'(n_deq);
      tail  <= tail + PW'(n_acc);
      count <= count + n_acc - n_deq;
    end
  end

  // Pointer arithmetic wraps naturally, so a group straddling the end stays contiguous.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int j = 0; j < DEPTH; j++) begin
        mem_inst[j] <= '0;
        mem_pc4[j]  <= '0;
        mem_btb[j]  <= '0;
        mem_br[j]   <= 1'b0;
        mem_dir[j]  <= 1'b0;
      end
    end else if (!flush && enq_ok) begin
      for (int i = 0; i < W; i++) begin
        if (CW'(i) < n_enq) begin
          mem_inst[wr_idx[i]] <= in_inst[i*DW +: DW];
          mem_pc4[wr_idx[i]]  <= in_pc4[i*DW +: DW];
          mem_btb[wr_idx[i]]  <= in_btb_pc[i*DW +: DW];
          mem_br[wr_idx[i]]   <= in_br_valid[i];
          mem_dir[wr_idx[i]]  <= in_dir_pred[i];
        end
      end
    end
  end

  // A stalled cycle drops valid but keeps the last issued data on the lanes.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_valid    <= '0;
      out_inst     <= '0;
      out_pc4      <= '0;
      out_br_valid <= '0;
      out_btb_pc   <= '0;
      out_dir_pred <= '0;
    end else if (flush) begin
      out_valid    <= '0;
      out_inst     <= '0;
      out_pc4      <= '0;
      out_br_valid <= '0;
      out_btb_pc   <= '0;
      out_dir_pred <= '0;
    end else if (deq_go) begin
      for (int i = 0; i < W; i++) begin
        if (CW'(i) < n_deq) begin
          out_valid[i]           <= 1'b1;
          out_inst[i*DW +: DW]   <= mem_inst[rd_idx[i]];
          out_pc4[i*DW +: DW]    <= mem_pc4[rd_idx[i]];
          out_btb_pc[i*DW +: DW] <= mem_btb[rd_idx[i]];
          out_br_valid[i]        <= mem_br[rd_idx[i]];
          out_dir_pred[i]        <= mem_dir[rd_idx[i]];
        end else begin
          out_valid[i]           <= 1'b0;
          out_inst[i*DW +: DW]   <= '0;
          out_pc4[i*DW +: DW]    <= '0;
          out_btb_pc[i*DW +: DW] <= '0;
          out_br_valid[i]        <= 1'b0;
          out_dir_pred[i]        <= 1'b0;
        end
      end
    end else begin
      out_valid <= '0;
    end
  end

endmodule

// File: tb/tb_iq_wide.sv
// tb/tb_iq_wide.sv - directed self-checking bench for iq_wide
// W=2, DEPTH=16; inputs change 1ns after the rising edge, outputs sampled there.
module tb_iq_wide;

  localparam int DEPTH = 16;
  localparam int W     = 2;
  localparam int DW    = 32;

  logic            clk = 1'b0;
  logic            rst;
  logic            flush;
  logic            stall_backend;
  logic [1:0]      deq_max;
  logic [W-1:0]    in_valid;
  logic [W*DW-1:0] in_inst, in_pc4, in_btb_pc;
  logic [W-1:0]    in_br_valid, in_dir_pred;
  logic            in_ready;
  logic [W-1:0]    out_valid;
  logic [W*DW-1:0] out_inst, out_pc4, out_btb_pc;
  logic [W-1:0]    out_br_valid, out_dir_pred;
  logic [4:0]      count;
  logic            empty, full;

  int n_cmp = 0;
  int n_bad = 0;
  int ptr   = 0;

  iq_wide #(.DEPTH(DEPTH), .W(W), .DW(DW)) dut (
    .clk(clk), .rst(rst), .flush(flush), .stall_backend(stall_backend),
    .deq_max(deq_max), .in_valid(in_valid), .in_inst(in_inst), .in_pc4(in_pc4),
    .in_br_valid(in_br_valid), .in_btb_pc(in_btb_pc), .in_dir_pred(in_dir_pred),
    .in_ready(in_ready), .out_valid(out_valid), .out_inst(out_inst),
    .out_pc4(out_pc4), .out_br_valid(out_br_valid), .out_btb_pc(out_btb_pc),
    .out_dir_pred(out_dir_pred), .count(count), .empty(empty), .full(full)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_lane(input int i, input logic [31:0] inst, input logic [31:0] pc4,
                          input logic br, input logic [31:0] btb, input logic dir);
    in_inst[i*DW +: DW]   = inst;
    in_pc4[i*DW +: DW]    = pc4;
    in_btb_pc[i*DW +: DW] = btb;
    in_br_valid[i]        = br;
    in_dir_pred[i]        = dir;
  endtask

  task automatic test_reset();
    rst = 1'b0; flush = 1'b0; stall_backend = 1'b0; deq_max = 2'd2;
    in_valid = '0; in_inst = '0; in_pc4 = '0; in_btb_pc = '0;
    in_br_valid = '0; in_dir_pred = '0;
    #2;
    n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
    n_cmp++; if (empty !== 1'b1) begin n_bad++; $display("FAIL reset_empty: got %b want 1", empty); end
    n_cmp++; if (full !== 1'b0) begin n_bad++; $display("FAIL reset_full: got %b want 0", full); end
    n_cmp++; if (count !== 5'd0) begin n_bad++; $display("FAIL reset_count: got %0d want 0", count); end
    n_cmp++; if (out_valid !== 2'b00) begin n_bad++; $display("FAIL reset_out_valid: got %b want 00", out_valid); end
    step();
    rst = 1'b1;
  endtask

  task automatic test_basic();
    set_lane(0, 32'hA000_0001, 32'h0000_1004, 1'b1, 32'h0000_0400, 1'b1);
    set_lane(1, 32'hB000_0002, 32'h0000_1008, 1'b0, 32'h0000_0000, 1'b0);
    in_valid = 2'b11; deq_max = 2'd2; stall_backend = 1'b0;
    step();
    n_cmp++; if (count !== 5'd2) begin n_bad++; $display("FAIL basic_count: got %0d want 2", count); end
    n_cmp++; if (out_valid !== 2'b00) begin n_bad++; $display("FAIL basic_no_bypass: got %b want 00", out_valid); end
    in_valid = 2'b00;
    step();
    n_cmp++; if (out_valid !== 2'b11) begin n_bad++; $display("FAIL basic_out_valid: got %b want 11", out_valid); end
    n_cmp++; if (out_inst !== {32'hB000_0002, 32'hA000_0001}) begin n_bad++; $display("FAIL basic_inst: got %h want b0000002a0000001", out_inst); end
    n_cmp++; if (out_pc4 !== {32'h0000_1008, 32'h0000_1004}) begin n_bad++; $display("FAIL basic_pc4: got %h want 0000100800001004", out_pc4); end
    n_cmp++; if (out_br_valid !== 2'b01 || out_dir_pred !== 2'b01) begin n_bad++; $display("FAIL basic_meta: got br %b dir %b want 01 01", out_br_valid, out_dir_pred); end
    n_cmp++; if (out_btb_pc[31:0] !== 32'h0000_0400) begin n_bad++; $display("FAIL basic_btb: got %h want 00000400", out_btb_pc[31:0]); end
    n_cmp++; if (count !== 5'd0) begin n_bad++; $display("FAIL basic_count_after: got %0d want 0", count); end
    ptr = ptr + 2;
  endtask

  task automatic test_fill();
    stall_backend = 1'b1;
    for (int k = 0; k < 8; k++) begin
      set_lane(0, 32'h0000_1000 + 32'(2*k), 32'h0, 1'b0, 32'h0, 1'b0);
      set_lane(1, 32'h0000_1001 + 32'(2*k), 32'h0, 1'b0, 32'h0, 1'b0);
      in_valid = 2'b11;
      step();
    end
    n_cmp++; if (count !== 5'd16) begin n_bad++; $display("FAIL fill_count: got %0d want 16", count); end
    n_cmp++; if (full !== 1'b1 || in_ready !== 1'b0) begin n_bad++; $display("FAIL fill_flags: got full %b ready %b want 1 0", full, in_ready); end
    set_lane(0, 32'hDEAD_0000, 32'h0, 1'b0, 32'h0, 1'b0);
    set_lane(1, 32'hDEAD_0001, 32'h0, 1'b0, 32'h0, 1'b0);
    step();
    n_cmp++; if (count !== 5'd16) begin n_bad++; $display("FAIL fill_reject: got %0d want 16", count); end
    n_cmp++; if (out_valid !== 2'b00) begin n_bad++; $display("FAIL fill_stall_valid: got %b want 00", out_valid); end
    in_valid = 2'b00; stall_backend = 1'b0; deq_max = 2'd2;
    step();
    n_cmp++; if (out_inst !== {32'h0000_1001, 32'h0000_1000} || out_valid !== 2'b11) begin n_bad++; $display("FAIL fill_first_pair: got %h v %b want 0000100100001000 v 11", out_inst, out_valid); end
    n_cmp++; if (count !== 5'd14) begin n_bad++; $display("FAIL fill_drain_count: got %0d want 14", count); end
    for (int k = 0; k < 7; k++) step();
    n_cmp++; if (out_inst !== {32'h0000_100F, 32'h0000_100E}) begin n_bad++; $display("FAIL fill_last_pair: got %h want 0000100f0000100e", out_inst); end
    n_cmp++; if (count !== 5'd0 || empty !== 1'b1) begin n_bad++; $display("FAIL fill_drained: got count %0d empty %b want 0 1", count, empty); end
    step();
    n_cmp++; if (out_valid !== 2'b00 || out_inst !== 64'h0) begin n_bad++; $display("FAIL fill_idle: got v %b inst %h want 00 0", out_valid, out_inst); end
  endtask

  task automatic test_single();
    stall_backend = 1'b1; deq_max = 2'd1;
    set_lane(0, 32'hA000_0001, 32'h0000_1004, 1'b1, 32'h0000_0400, 1'b1);
    set_lane(1, 32'hB000_0002, 32'h0000_1008, 1'b0, 32'h0000_0000, 1'b0);
    in_valid = 2'b11;
    step();
    set_lane(0, 32'hC000_0003, 32'h0000_100C, 1'b1, 32'h0000_0800, 1'b0);
    set_lane(1, 32'hEEEE_EEEE, 32'hEEEE_EEEE, 1'b1, 32'hEEEE_EEEE, 1'b1);
    in_valid = 2'b01;
    step();
    n_cmp++; if (count !== 5'd3) begin n_bad++; $display("FAIL single_count: got %0d want 3", count); end
    in_valid = 2'b00; stall_backend = 1'b0;
    step();
    n_cmp++; if (out_valid !== 2'b01 || out_inst[31:0] !== 32'hA000_0001) begin n_bad++; $display("FAIL single_a: got v %b inst %h want 01 a0000001", out_valid, out_inst[31:0]); end
    n_cmp++; if (out_br_valid !== 2'b01 || out_dir_pred !== 2'b01 || out_btb_pc[31:0] !== 32'h400) begin n_bad++; $display("FAIL single_a_meta: got br %b dir %b btb %h want 01 01 400", out_br_valid, out_dir_pred, out_btb_pc[31:0]); end
    step();
    n_cmp++; if (out_valid !== 2'b01 || out_inst[31:0] !== 32'hB000_0002 || out_pc4[31:0] !== 32'h1008) begin n_bad++; $display("FAIL single_b: got v %b inst %h pc4 %h want 01 b0000002 1008", out_valid, out_inst[31:0], out_pc4[31:0]); end
    n_cmp++; if (out_br_valid !== 2'b00 || out_dir_pred !== 2'b00 || count !== 5'd1) begin n_bad++; $display("FAIL single_b_meta: got br %b dir %b count %0d want 00 00 1", out_br_valid, out_dir_pred, count); end
    step();
    n_cmp++; if (out_valid !== 2'b01 || out_inst[31:0] !== 32'hC000_0003) begin n_bad++; $display("FAIL single_c: got v %b inst %h want 01 c0000003", out_valid, out_inst[31:0]); end
    n_cmp++; if (out_br_valid !== 2'b01 || out_dir_pred !== 2'b00 || out_btb_pc[31:0] !== 32'h800) begin n_bad++; $display("FAIL single_c_meta: got br %b dir %b btb %h want 01 00 800", out_br_valid, out_dir_pred, out_btb_pc[31:0]); end
    step();
    n_cmp++; if (out_valid !== 2'b00 || count !== 5'd0) begin n_bad++; $display("FAIL single_end: got v %b count %0d want 00 0", out_valid, count); end
    ptr = ptr + 3;
  endtask

  task automatic test_partial();
    stall_backend = 1'b1;
    set_lane(0, 32'hD000_0004, 32'h0000_1010, 1'b0, 32'h0, 1'b1);
    in_valid = 2'b01;
    step();
    stall_backend = 1'b0; deq_max = 2'd2;
    set_lane(1, 32'hF000_0005, 32'h0000_1014, 1'b0, 32'h0, 1'b0);
    in_valid = 2'b10;
    step();
    n_cmp++; if (out_valid !== 2'b01 || out_inst !== {32'h0, 32'hD000_0004}) begin n_bad++; $display("FAIL partial_out: got v %b inst %h want 01 00000000d0000004", out_valid, out_inst); end
    n_cmp++; if (count !== 5'd0) begin n_bad++; $display("FAIL partial_count: got %0d want 0", count); end
    step();
    n_cmp++; if (count !== 5'd0 || empty !== 1'b1 || out_valid !== 2'b00) begin n_bad++; $display("FAIL partial_gap_lane: got count %0d empty %b v %b want 0 1 00", count, empty, out_valid); end
    in_valid = 2'b00;
    ptr = ptr + 1;
  endtask

  task automatic test_wrap();
    int n;
    n = (15 - ptr) & 15;
    stall_backend = 1'b1;
    set_lane(0, 32'h7777_0000, 32'h0, 1'b0, 32'h0, 1'b0);
    in_valid = 2'b01;
    for (int k = 0; k < n; k++) step();
    in_valid = 2'b00; stall_backend = 1'b0; deq_max = 2'd2;
    for (int k = 0; k < n; k++) step();
    n_cmp++; if (count !== 5'd0) begin n_bad++; $display("FAIL wrap_prep: got %0d want 0", count); end
    stall_backend = 1'b1;
    set_lane(0, 32'h5800_0001, 32'h0000_2004, 1'b1, 32'h0000_0123, 1'b1);
    set_lane(1, 32'h5900_0002, 32'h0000_2008, 1'b0, 32'h0000_0000, 1'b1);
    in_valid = 2'b11;
    step();
    n_cmp++; if (count !== 5'd2) begin n_bad++; $display("FAIL wrap_count: got %0d want 2", count); end
    in_valid = 2'b00; stall_backend = 1'b0; deq_max = 2'd1;
    step();
    n_cmp++; if (out_inst[31:0] !== 32'h5800_0001 || out_btb_pc[31:0] !== 32'h123 || out_br_valid !== 2'b01) begin n_bad++; $display("FAIL wrap_x: got inst %h btb %h br %b want 58000001 123 01", out_inst[31:0], out_btb_pc[31:0], out_br_valid); end
    step();
    n_cmp++; if (out_inst[31:0] !== 32'h5900_0002 || out_pc4[31:0] !== 32'h2008 || out_dir_pred !== 2'b01 || out_valid !== 2'b01) begin n_bad++; $display("FAIL wrap_y: got inst %h pc4 %h dir %b v %b want 59000002 2008 01 01", out_inst[31:0], out_pc4[31:0], out_dir_pred, out_valid); end
    ptr = 1;
  endtask

  task automatic test_flush();
    stall_backend = 1'b1; deq_max = 2'd2;
    set_lane(0, 32'h1111_0000, 32'h0, 1'b1, 32'h0, 1'b1);
    set_lane(1, 32'h2222_0000, 32'h0, 1'b1, 32'h0, 1'b1);
    in_valid = 2'b11;
    step();
    step();
    in_valid = 2'b01;
    step();
    n_cmp++; if (count !== 5'd5) begin n_bad++; $display("FAIL flush_prep: got %0d want 5", count); end
    stall_backend = 1'b0; flush = 1'b1; in_valid = 2'b11;
    step();
    n_cmp++; if (count !== 5'd0 || empty !== 1'b1 || in_ready !== 1'b1) begin n_bad++; $display("FAIL flush_state: got count %0d empty %b ready %b want 0 1 1", count, empty, in_ready); end
    n_cmp++; if (out_valid !== 2'b00 || out_inst !== 64'h0) begin n_bad++; $display("FAIL flush_out: got v %b inst %h want 00 0", out_valid, out_inst); end
    flush = 1'b0; in_valid = 2'b00;
    step();
    n_cmp++; if (count !== 5'd0 || out_valid !== 2'b00) begin n_bad++; $display("FAIL flush_after: got count %0d v %b want 0 00", count, out_valid); end
  endtask

  task automatic test_async_reset();
    stall_backend = 1'b0; deq_max = 2'd2;
    set_lane(0, 32'h3333_0000, 32'h0, 1'b0, 32'h0, 1'b0);
    set_lane(1, 32'h4444_0000, 32'h0, 1'b0, 32'h0, 1'b0);
    in_valid = 2'b11;
    step();
    step();
    n_cmp++; if (out_valid !== 2'b11 || count !== 5'd2) begin n_bad++; $display("FAIL burst_live: got v %b count %0d want 11 2", out_valid, count); end
    #2 rst = 1'b0;
    #1;
    n_cmp++; if (out_valid !== 2'b00 || out_inst !== 64'h0) begin n_bad++; $display("FAIL async_out: got v %b inst %h want 00 0", out_valid, out_inst); end
    n_cmp++; if (count !== 5'd0 || empty !== 1'b1) begin n_bad++; $display("FAIL async_count: got %0d empty %b want 0 1", count, empty); end
    in_valid = 2'b00;
    step();
    rst = 1'b1;
    step();
    n_cmp++; if (count !== 5'd0 || out_valid !== 2'b00) begin n_bad++; $display("FAIL async_release: got count %0d v %b want 0 00", count, out_valid); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_fill();
    test_single();
    test_partial();
    test_wrap();
    test_flush();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
